// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared CPU bus definitions: mux/destination codes, legality ranges and the
// transfer sequencer state encoding.
package bus_transfer_sequencer_pkg;

  localparam int CODE_W = 5;
  localparam int BUS_W  = 32;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_R0      = 5'd1;
  localparam code_t CODE_R15     = 5'd16;
  localparam code_t CODE_HI      = 5'd17;
  localparam code_t CODE_LO      = 5'd18;
  localparam code_t CODE_ZHIGH   = 5'd19;
  localparam code_t CODE_ZLOW    = 5'd20;
  localparam code_t CODE_PC      = 5'd21;
  localparam code_t CODE_MDR     = 5'd22;
  localparam code_t CODE_INPORT  = 5'd23;
  localparam code_t CODE_C       = 5'd24;
  localparam code_t CODE_Y       = 5'd25;
  localparam code_t CODE_MAR     = 5'd26;
  localparam code_t CODE_OUTPORT = 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Anything that can be placed on the bus: R0 through Y.
  function automatic logic src_legal(code_t code);
    return (code >= CODE_R0) && (code <= CODE_Y);
  endfunction

  // Loadable registers only; Z halves, InPort and C are read-only from the bus.
  function automatic logic dst_legal(code_t code);
    return ((code >= CODE_R0) && (code <= CODE_LO)) ||
           (code == CODE_PC) || (code == CODE_MDR) ||
           ((code >= CODE_Y) && (code <= CODE_OUTPORT));
  endfunction

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// Request handshake and bus-side signals of the transfer sequencer.
interface bus_transfer_sequencer_if
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int COUNT_W = 16
);

  logic               req_valid;
  code_t              req_src;
  code_t              req_dst;
  logic               req_ready;
  logic [BUS_W-1:0]   bus_in;
  code_t              select_signal;
  logic [BUS_W-1:0]   dst_en;
  logic [BUS_W-1:0]   bus_capture;
  logic               done;
  logic               err;
  logic               busy;
  logic [COUNT_W-1:0] xfer_count;

  modport master (
    output req_valid, req_src, req_dst, bus_in,
    input  req_ready, select_signal, dst_en, bus_capture, done, err, busy, xfer_count
  );

  modport slave (
    input  req_valid, req_src, req_dst, bus_in,
    output req_ready, select_signal, dst_en, bus_capture, done, err, busy, xfer_count
  );

endinterface

// File: rtl/bus_transfer_sequencer_dest_decoder.sv
// Destination decoder: 5-bit code to one-hot load enable, plus legality flag.
module bus_dest_decoder
  import bus_transfer_sequencer_pkg::*;
(
  input  code_t            code,
  input  logic             en,
  output logic [BUS_W-1:0] onehot,
  output logic             legal
);

  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no
    // path leaves a value unassigned and no latch is inferred.
    onehot = '0;
    legal  = dst_legal(code);
    if (en && legal) begin
      onehot[code] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Register-to-register bus transfer sequencer: IDLE -> DRIVE (settle) -> LOAD.
module bus_transfer_sequencer
  import bus_transfer_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 16
) (
  input logic clock,
  input logic clear,
  bus_transfer_sequencer_if.slave bus
);

  localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE_CYCLES - 1);

  state_e             state;
  state_e             state_next;
  code_t              src_q;
  code_t              dst_q;
  code_t              dec_code;
  logic [1:0]         settle_cnt;
  logic               err_q;
  logic [BUS_W-1:0]   capture_q;
  logic [COUNT_W-1:0] xfer_count_q;
  logic               handshake;
  logic               req_legal;
  logic               dst_code_legal;
  logic               load_active;

  assign handshake = bus.req_valid && bus.req_ready;
  assign req_legal = src_legal(bus.req_src) && dst_code_legal;

  // One decoder serves both jobs: legality of the incoming dst while idle,
  // and the one-hot strobe from the latched dst during LOAD.
  assign dec_code    = (state == ST_IDLE) ? bus.req_dst : dst_q;
  assign load_active = (state == ST_LOAD) && !clear;

  bus_dest_decoder u_dest_decoder (
    .code   (dec_code),
    .en     (load_active),
    .onehot (bus.dst_en),
    .legal  (dst_code_legal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (handshake && req_legal) state_next = ST_DRIVE;
      ST_DRIVE: if (settle_cnt == 2'd0)     state_next = ST_LOAD;
      ST_LOAD:                              state_next = ST_IDLE;
      default:                              state_next = ST_IDLE;
    endcase
  end

  // Outputs are gated by clear so an aborted LOAD never strobes a register.
  always_comb begin
    bus.req_ready     = (state == ST_IDLE) && !clear;
    bus.busy          = (state != ST_IDLE);
    bus.done          = load_active;
    bus.select_signal = '0;
    if ((state != ST_IDLE) && !clear) begin
      bus.select_signal = src_q;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      src_q        <= '0;
      dst_q        <= '0;
      settle_cnt   <= '0;
      err_q        <= 1'b0;
      capture_q    <= '0;
      xfer_count_q <= '0;
    end else begin
      err_q <= handshake && !req_legal;
      if (handshake && req_legal) begin
        src_q      <= bus.req_src;
        dst_q      <= bus.req_dst;
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == ST_DRIVE) && (settle_cnt != 2'd0)) begin
        settle_cnt <= settle_cnt - 2'd1;
      end
      if (state == ST_LOAD) begin
        capture_q    <= bus.bus_in;
        xfer_count_q <= xfer_count_q + COUNT_W'(1);
      end
    end
  end

  assign bus.err         = err_q;
  assign bus.bus_capture = capture_q;
  assign bus.xfer_count  = xfer_count_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Self-checking bench: directed latency/reset sequences, a vector table and a
// scoreboard that pairs each accepted request with its done/err pulse.
module tb_bus_transfer_sequencer;
  import bus_transfer_sequencer_pkg::*;

  logic clock = 1'b0;
  logic clear1;
  logic clear3;
  always #5 clock = ~clock;

  bus_transfer_sequencer_if #(.COUNT_W(16)) if1 ();
  bus_transfer_sequencer_if #(.COUNT_W(16)) if3 ();

  bus_transfer_sequencer #(.SETTLE_CYCLES(1), .COUNT_W(16)) dut1 (
    .clock (clock),
    .clear (clear1),
    .bus   (if1)
  );

  bus_transfer_sequencer #(.SETTLE_CYCLES(3), .COUNT_W(16)) dut3 (
    .clock (clock),
    .clear (clear3),
    .bus   (if3)
  );

  typedef struct {
    code_t       src;
    code_t       dst;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_dst_en;
  } vec_t;

  typedef struct {
    logic        is_err;
    code_t       src;
    logic [31:0] dst_en;
    logic [31:0] data;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  bit          mon_en   = 1'b0;
  bit          cap_pending = 1'b0;
  logic [31:0] cap_exp;
  exp_t        sb_q[$];
  exp_t        mon_e;
  vec_t        vecs[20];
  int          exp_count;
  int          hs_cyc[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(posedge clock) cyc++;

  // Scoreboard: every done/err pulse on dut1 must match the oldest request.
  always @(negedge clock) begin
    if (if1.done) done_cnt++;
    if (cap_pending) begin
      check("sb_capture", if1.bus_capture, cap_exp);
      cap_pending = 1'b0;
    end
    if (mon_en) begin
      if (if1.done || if1.err) begin
        check("sb_nonempty", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("sb_kind", {if1.done, if1.err}, mon_e.is_err ? 2'b01 : 2'b10);
          check("sb_dst_en", if1.dst_en, mon_e.dst_en);
          if (!mon_e.is_err) begin
            check("sb_select", if1.select_signal, mon_e.src);
            cap_pending = 1'b1;
            cap_exp     = mon_e.data;
          end
        end
      end else begin
        check("no_stray_dst_en", if1.dst_en, 0);
      end
    end
  end

  // Call just after a rising edge; returns just after the handshake edge (cycle N+1).
  task automatic req1(input code_t s, input code_t d, input logic [31:0] data);
    if1.req_valid = 1'b1;
    if1.req_src   = s;
    if1.req_dst   = d;
    if1.bus_in    = data;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (if1.req_ready) break;
      @(posedge clock); #1;
    end
    check("req_ready_seen", if1.req_ready, 1);
    @(posedge clock); #1;
    if1.req_valid = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{5'd2,  5'd5,  32'hDEADBEEF, 1'b0, 32'h0000_0020},
      '{5'd4,  5'd4,  32'hA5A5A5A5, 1'b0, 32'h0000_0010},
      '{5'd25, 5'd27, 32'h0000_0001, 1'b0, 32'h0800_0000},
      '{5'd24, 5'd26, 32'hFFFF_FFFF, 1'b0, 32'h0400_0000},
      '{5'd23, 5'd1,  32'h1357_2468, 1'b0, 32'h0000_0002},
      '{5'd17, 5'd18, 32'h0F0F_0F0F, 1'b0, 32'h0004_0000},
      '{5'd16, 5'd16, 32'h8000_0000, 1'b0, 32'h0001_0000},
      '{5'd22, 5'd21, 32'h2222_1111, 1'b0, 32'h0020_0000},
      '{5'd21, 5'd22, 32'h3333_4444, 1'b0, 32'h0040_0000},
      '{5'd1,  5'd25, 32'h5555_AAAA, 1'b0, 32'h0200_0000},
      '{5'd0,  5'd5,  32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd26, 5'd5,  32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd31, 5'd3,  32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd3,  5'd0,  32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd3,  5'd20, 32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd3,  5'd23, 32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd3,  5'd24, 32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd3,  5'd28, 32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd3,  5'd31, 32'h0000_0BAD, 1'b1, 32'h0000_0000},
      '{5'd0,  5'd0,  32'h0000_0BAD, 1'b1, 32'h0000_0000}
    };

    if1.req_valid = 1'b0; if1.req_src = '0; if1.req_dst = '0; if1.bus_in = '0;
    if3.req_valid = 1'b0; if3.req_src = '0; if3.req_dst = '0; if3.bus_in = '0;
    clear1 = 1'b1;
    clear3 = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, ready held low while clear is high
    @(negedge clock);
    check("rst_ready_low",   if1.req_ready, 0);
    check("rst_ready_low3",  if3.req_ready, 0);
    check("rst_busy",        if1.busy, 0);
    check("rst_select",      if1.select_signal, 0);
    check("rst_dst_en",      if1.dst_en, 0);
    check("rst_capture",     if1.bus_capture, 0);
    check("rst_done_err",    {if1.done, if1.err}, 0);
    check("rst_count",       if1.xfer_count, 0);
    @(posedge clock); #1;
    clear1 = 1'b0;
    clear3 = 1'b0;
    @(negedge clock);
    check("idle_ready", if1.req_ready, 1);

    // Clear during DRIVE aborts the transfer
    @(posedge clock); #1;
    req1(5'd3, 5'd7, 32'h1111_2222);
    clear1 = 1'b1;
    @(negedge clock);
    check("drv_busy", if1.busy, 1);
    check("clr_ready_low", if1.req_ready, 0);
    @(posedge clock); #1;
    clear1 = 1'b0;
    @(negedge clock);
    check("clr_drv_busy",   if1.busy, 0);
    check("clr_drv_select", if1.select_signal, 0);
    check("clr_drv_done",   if1.done, 0);
    check("clr_drv_dst_en", if1.dst_en, 0);
    check("clr_drv_count",  if1.xfer_count, 0);
    check("clr_drv_ready",  if1.req_ready, 1);
    @(posedge clock); #1;
    @(negedge clock);
    check("clr_drv_no_late_done", if1.done, 0);

    // Clear during LOAD suppresses the strobe and the count
    @(posedge clock); #1;
    req1(5'd4, 5'd8, 32'h3333_4444);
    @(posedge clock); #1;
    clear1 = 1'b1;
    @(negedge clock);
    check("clr_load_done",   if1.done, 0);
    check("clr_load_dst_en", if1.dst_en, 0);
    @(posedge clock); #1;
    clear1 = 1'b0;
    @(negedge clock);
    check("clr_load_count",   if1.xfer_count, 0);
    check("clr_load_busy",    if1.busy, 0);
    check("clr_load_capture", if1.bus_capture, 0);

    // R1 -> R4 with exact cycle latency
    @(posedge clock); #1;
    req1(5'd2, 5'd5, 32'hDEADBEEF);
    @(negedge clock);
    check("lat_n1_select", if1.select_signal, 2);
    check("lat_n1_done",   if1.done, 0);
    check("lat_n1_dst_en", if1.dst_en, 0);
    check("lat_n1_ready",  if1.req_ready, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("lat_n2_select", if1.select_signal, 2);
    check("lat_n2_dst_en", if1.dst_en, 32'h0000_0020);
    check("lat_n2_done",   if1.done, 1);
    @(posedge clock); #1;
    @(negedge clock);
    check("lat_n3_ready",   if1.req_ready, 1);
    check("lat_n3_done",    if1.done, 0);
    check("lat_n3_select",  if1.select_signal, 0);
    check("lat_n3_capture", if1.bus_capture, 32'hDEADBEEF);
    check("lat_n3_count",   if1.xfer_count, 1);
    exp_count = 1;

    // Illegal destination Z_high
    @(posedge clock); #1;
    req1(5'd6, 5'd19, 32'hCAFE_F00D);
    @(negedge clock);
    check("zh_err",    if1.err, 1);
    check("zh_ready",  if1.req_ready, 1);
    check("zh_dst_en", if1.dst_en, 0);
    check("zh_busy",   if1.busy, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check("zh_err_pulse", if1.err, 0);
    check("zh_count",     if1.xfer_count, exp_count);

    // Vector table through the scoreboard
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      req1(vecs[i].src, vecs[i].dst, vecs[i].data);
      sb_q.push_back('{vecs[i].exp_err, vecs[i].src, vecs[i].exp_dst_en, vecs[i].data});
      if (vecs[i].exp_err) begin
        @(negedge clock);
        check("tbl_err_ready", if1.req_ready, 1);
        check("tbl_err_count", if1.xfer_count, exp_count);
      end else begin
        exp_count++;
        repeat (2) begin
          @(posedge clock); #1;
        end
        @(negedge clock);
        check("tbl_count", if1.xfer_count, exp_count);
      end
    end

    // Back-to-back requests with req_valid held high
    @(posedge clock); #1;
    done_cnt = 0;
    if1.req_valid = 1'b1;
    if1.req_src   = 5'd9;
    if1.req_dst   = 5'd10;
    if1.bus_in    = 32'h0BAD_F00D;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        @(negedge clock);
        if (if1.req_ready) break;
        @(posedge clock); #1;
      end
      check("b2b_ready", if1.req_ready, 1);
      hs_cyc[k] = cyc;
      @(posedge clock); #1;
      sb_q.push_back('{1'b0, if1.req_src, 32'h1 << if1.req_dst, 32'h0BAD_F00D});
      if (k < 2) begin
        if1.req_src = if1.req_src + 5'd1;
        if1.req_dst = if1.req_dst + 5'd1;
      end else begin
        if1.req_valid = 1'b0;
      end
    end
    repeat (3) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    exp_count += 3;
    check("b2b_gap1",  hs_cyc[1] - hs_cyc[0], 3);
    check("b2b_gap2",  hs_cyc[2] - hs_cyc[1], 3);
    check("b2b_dones", done_cnt, 3);
    check("b2b_count", if1.xfer_count, exp_count);
    mon_en = 1'b0;
    check("sb_drained", sb_q.size(), 0);

    // Counter wrap from all-ones
    @(posedge clock); #1;
    force dut1.xfer_count_q = 16'hFFFF;
    #1;
    release dut1.xfer_count_q;
    req1(5'd1, 5'd2, 32'h0000_00AA);
    repeat (2) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("wrap_count", if1.xfer_count, 16'h0000);

    // SETTLE_CYCLES=3: PC -> MAR
    @(posedge clock); #1;
    if3.req_valid = 1'b1;
    if3.req_src   = 5'd21;
    if3.req_dst   = 5'd26;
    if3.bus_in    = 32'h1234_5678;
    @(negedge clock);
    check("s3_ready", if3.req_ready, 1);
    @(posedge clock); #1;
    if3.req_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c <= 4) check("s3_select", if3.select_signal, 21);
      else        check("s3_ready_back", if3.req_ready, 1);
      check("s3_done",   if3.done, (c == 4) ? 1 : 0);
      check("s3_dst_en", if3.dst_en, (c == 4) ? 32'h0400_0000 : 32'h0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("s3_capture", if3.bus_capture, 32'h1234_5678);
    check("s3_count",   if3.xfer_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_transfer_sequencer.md
BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving the number of bus-settle cycles before the load strobe (legal range 1..4).
REQ-002 SHALL have parameter COUNT_W, default 16, giving the width of the transfer counter.
REQ-003 SHALL have port clock  in  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port clear  in  1  the reset: synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  transfer request present.
REQ-006 SHALL have port req_src  in  5  source code, same encoding as the bus mux select (R0=1..R15=16, HI=17, LO=18, Zhigh=19, Zlow=20, PC=21, MDR=22, InPort=23, C=24, Y=25).
REQ-007 SHALL have port req_dst  in  5  destination code (R0=1..R15=16, HI=17, LO=18, PC=21, MDR=22, Y=25, MAR=26, OutPort=27).
REQ-008 SHALL have port req_ready  out  1  request accepted on a cycle where req_valid and req_ready are both high.
REQ-009 SHALL have port bus_in  in  32  the bus mux output.
REQ-010 SHALL have port select_signal  out  5  drives the bus mux select.
REQ-011 SHALL have port dst_en  out  32  one-hot load enable, bit index = destination code.
REQ-012 SHALL have port bus_capture  out  32  bus value sampled during the load cycle.
REQ-013 SHALL have port done  out  1  one-cycle pulse on a completed transfer.
REQ-014 SHALL have port err  out  1  one-cycle pulse on a rejected request.
REQ-015 SHALL have port busy  out  1  high in any non-IDLE state.
REQ-016 SHALL have port xfer_count  out  COUNT_W  number of completed transfers.

Function
REQ-017 SHALL implement states IDLE, DRIVE and LOAD.
REQ-018 SHALL hold req_ready high only in IDLE, so at most one transfer is in flight.
REQ-019 SHALL go IDLE->DRIVE on a handshake with a legal request, latching req_src and req_dst.
REQ-020 SHALL treat src codes 0 and 26..31 as illegal, and dst codes 0, 19, 20, 23, 24 and 28..31 as illegal.
REQ-021 SHALL, on a handshake with any illegal code, pulse err in the next cycle, latch nothing and stay in IDLE.
REQ-022 SHALL, in DRIVE, drive select_signal with the latched src and stay for SETTLE_CYCLES cycles using a down-counter, then go to LOAD.
REQ-023 SHALL, in LOAD (exactly one cycle), hold select_signal, assert dst_en[dst], capture bus_in into bus_capture, pulse done, increment xfer_count, then return to IDLE.
REQ-024 SHALL give latency: with a handshake in cycle N, done is high in cycle N+1+SETTLE_CYCLES, and req_ready is high again in cycle N+2+SETTLE_CYCLES.
REQ-025 SHALL drive select_signal to 0 and dst_en to 0 in IDLE, so the mux outputs zero.
REQ-026 SHALL never have more than one dst_en bit high, and only in LOAD.
REQ-027 SHALL allow src and dst to be the same register (e.g. R3->R3) and perform the transfer normally.
REQ-028 SHALL wrap xfer_count from all-ones to 0 with no flag.
REQ-029 SHALL hold bus_capture until the next LOAD.

Reset
REQ-030 SHALL, when clear is high at a clock edge, go to IDLE and set select_signal=0, dst_en=0, bus_capture=0, done=0, err=0, busy=0 and xfer_count=0.
REQ-031 SHALL, when clear is asserted mid-transfer (DRIVE or LOAD), abort the transfer with no dst_en and no done pulse, and leave xfer_count at 0.
REQ-032 SHALL hold req_ready low while clear is high.

Structure
REQ-033 SHALL place the source/destination code constants, the legality ranges and the state enumeration in the shared CPU package used by the bus mux.
REQ-034 SHALL contain one sub-module, bus_dest_decoder: combinational, mapping a 5-bit code plus an enable to the 32-bit one-hot dst_en and a legal flag.

Verification
REQ-035 SHALL check: request src=2 (R1), dst=5 (R4), bus_in=0xDEADBEEF, SETTLE_CYCLES=1 -> select_signal=2 in cycles N+1 and N+2; dst_en=0x00000020 and done in N+2; bus_capture=0xDEADBEEF; xfer_count=1.
REQ-036 SHALL check: request dst=19 (Z_high) -> err pulse in N+1, no dst_en, req_ready stays high, xfer_count unchanged.
REQ-037 SHALL check: SETTLE_CYCLES=3, src=21, dst=26 -> select_signal=21 for 4 cycles, dst_en=1<<26 and done in cycle N+4.
REQ-038 SHALL check: clear asserted in the DRIVE cycle -> next cycle is IDLE, select_signal=0, no done, xfer_count=0.
REQ-039 SHALL check: req_valid held high for 3 back-to-back legal requests -> req_ready accepts one per 3 cycles (SETTLE_CYCLES=1), 3 done pulses, xfer_count=3.
REQ-040 SHALL check: preload xfer_count to 0xFFFF and complete one transfer -> xfer_count=0x0000.
